// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and clear-engine state type for regfile_mp
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_fwd.sv
// rtl/regfile_fwd.sv - per-read-port write-bypass priority mux with zero-register masking
module regfile_fwd #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     stored,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0]     data
);

    // Ascending scan so the highest-index matching write port wins.
    always_comb begin
        data = stored;
        if (BYPASS) begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == addr)) begin
                    data = wr_data[i*DATA_W +: DATA_W];
                end
            end
        end
        if (ZERO_REG && (addr == '0)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass, busy scoreboard and bulk-clear engine
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  sb_set,
    input  logic [ADDR_W-1:0]     sb_addr,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    clr_state_e        state;
    clr_state_e        state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [NWR-1:0]    wr_act;
    logic              sb_act;
    logic              done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (ptr == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write ports and scoreboard sets are locked out while the clear sweeps.
    always_comb begin
        wr_act   = (state == IDLE) ? wr_en : '0;
        sb_act   = (state == IDLE) && sb_set;
        done_nxt = (state == CLEAR) && (ptr == LAST);
    end

    assign clr_busy = (state == CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            clr_done <= 1'b0;
        end else begin
            ptr      <= (state == CLEAR) ? ptr + 1'b1 : '0;
            clr_done <= done_nxt;
        end
    end

    // Later loop iterations override earlier ones, giving highest-port priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_act[i] && !(ZERO_REG && (wr_addr[i*ADDR_W +: ADDR_W] == '0))) begin
                    mem[wr_addr[i*ADDR_W +: ADDR_W]] <= wr_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Set is applied after the write clears so it wins on a same-address collision.
    always_comb begin
        busy_nxt = busy;
        if (state == CLEAR) begin
            busy_nxt[ptr] = 1'b0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wr_act[i]) begin
                    busy_nxt[wr_addr[i*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            if (sb_act) begin
                busy_nxt[sb_addr] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr       = rd_addr[g*ADDR_W +: ADDR_W];
        assign rd_busy[g] = busy[addr] && !(ZERO_REG && (addr == '0));

        regfile_fwd #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NWR      (NWR),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_fwd (
            .addr    (addr),
            .stored  (mem[addr]),
            .wr_en   (wr_act),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .data    (rd_data[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the processor datapath: a generalisation of the single-write, dual-read integer register file. It adds configurable width, depth and port counts, an optional hard-wired zero register, same-cycle write-to-read bypass, and a per-register busy scoreboard. A sequenced bulk-clear engine zeroes the file one entry per cycle without a reset. It sits between decode (read/scoreboard) and writeback (write ports).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NRD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, same packing
- rd_busy  out  NRD  scoreboard busy bit of each read address
- wr_en  in  NWR  write enables
- wr_addr  in  NWR*ADDR_W  write addresses
- wr_data  in  NWR*DATA_W  write data
- sb_set  in  1  mark sb_addr busy (instruction issued, result pending)
- sb_addr  in  ADDR_W  scoreboard set address
- clr_req  in  1  start bulk clear
- clr_busy  out  1  bulk clear in progress
- clr_done  out  1  one-cycle pulse on clear completion

Decided: one clock, `clk`; reset `rst_n` is asynchronous and active-low.

## Operation
- Reset (rst_n=0): all entries 0, all busy bits 0, FSM IDLE, clear pointer 0, clr_busy=0, clr_done=0; rd_data then reads 0.
- Writes: at the edge, each port i with wr_en[i] writes wr_data[i] to wr_addr[i]. If several ports target one address, the highest index wins. With ZERO_REG=1, writes to address 0 are dropped.
- Reads: combinational from rd_addr. With ZERO_REG=1, address 0 returns 0.
  - BYPASS=1: if an enabled write port matches the read address this cycle, that write's data is returned (highest index wins), except for address 0 under ZERO_REG.
  - BYPASS=0: the stored value is returned.
- Scoreboard: one busy bit per entry.
  - An enabled write clears the busy bit of its address.
  - sb_set sets the busy bit of sb_addr.
  - If set and clear hit the same address in one cycle, set wins.
  - rd_busy reflects stored busy bits only; there is no bypass on busy.
  - Address 0 is never busy when ZERO_REG=1.
- FSM IDLE/CLEAR:
  - IDLE to CLEAR: when clr_req=1. The pointer is loaded with 0.
  - In CLEAR, each edge zeroes the entry at the pointer plus its busy bit, then increments the pointer. Write ports and sb_set are ignored; reads return current contents.
  - After entry DEPTH-1 is cleared, return to IDLE and pulse clr_done.
  - clr_req while in CLEAR is ignored.
  - Pointer arithmetic is ADDR_W bits wide. Completion is detected on pointer == DEPTH-1, not on wrap-around.

## Timing
- Read path: zero latency, combinational. A write becomes visible in stored form on the cycle after the edge; with BYPASS=1 it is visible in the same cycle.
- Busy: a set or clear is visible on rd_busy the cycle after the edge.
- Clear: let clr_req be sampled at edge E0.
  - clr_busy is 1 from after E0 through edge E_DEPTH, i.e. exactly DEPTH cycles.
  - Entry k is zeroed at edge E(k+1).
  - clr_done=1 for the single cycle after E_DEPTH.
  - clr_busy and clr_done are registered.
- rst_n asserted mid-clear: immediate return to IDLE with everything zero; no clr_done pulse.

## Structure
- Shared package `regfile_pkg`: default DATA_W/ADDR_W constants and the FSM state enum (IDLE, CLEAR).
- One sub-module, `regfile_fwd`, is natural. It is a per-read-port priority mux over the write ports that selects bypass or stored data and applies the zero-register rule. It is instantiated NRD times.
- Storage, scoreboard and the clear FSM stay in the top module.

## Test plan
- Reset then read: rst_n low, then high; rd_addr 0..31 -> rd_data all 0, rd_busy all 0, clr_busy 0.
- Write/read with bypass: wr0 to r5 = 0xDEADBEEF while rd0 reads r5 -> same-cycle 0xDEADBEEF with BYPASS=1. With BYPASS=0, old value 0, then 0xDEADBEEF next cycle.
- Write collision and zero register: wr0 r7=0x11 and wr1 r7=0x22 in one cycle -> r7=0x22. A write of 0x55 to r0 -> r0 reads 0.
- Scoreboard: sb_set r3 -> rd_busy=1 next cycle. A write to r3 -> busy 0 next cycle. sb_set and write to r3 in the same cycle -> busy stays 1.
- Bulk clear: fill r1..r31 with nonzero values, pulse clr_req -> clr_busy high 32 cycles, r(k) zero after edge k+1, writes ignored meanwhile, clr_done one pulse, then all reads 0.
- Reset mid-clear: assert rst_n low after 10 clear cycles -> all entries 0, clr_busy 0 immediately, no clr_done.
